// File: rtl/dsm_pkg.sv
// dsm_pkg
//   Definitions shared by the transmit delta-sigma modulator and the loopback
//   receiver: symbol encodings, the ternary LO/mixer weight encoding, the CIC
//   order and helpers that size the CIC datapath from DECIM_LOG2.
package dsm_pkg;

  // 2-bit delta-sigma symbol as it leaves the modulator.
  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_POS  = 2'b01,
    SYM_NEG  = 2'b10,
    SYM_BAD  = 2'b11
  } sym_e;

  // Ternary weight encoding, identical to the transmit LO. 11 never appears
  // as a weight and is treated as zero wherever it is decoded.
  localparam logic [1:0] LO_W_ZERO = 2'b00;
  localparam logic [1:0] LO_W_POS  = 2'b01;
  localparam logic [1:0] LO_W_NEG  = 2'b10;

  localparam int CIC_ORDER = 3;

  // Integrator width: one sign bit, one bit of headroom for a +/-1 input,
  // plus CIC_ORDER * log2(R) bits of filter gain.
  function automatic int cic_acc_w(input int decim_log2);
    return 2 + CIC_ORDER * decim_log2;
  endfunction

  // Right shift that brings the full-scale CIC output down to 8 bits.
  function automatic int cic_shift(input int decim_log2);
    return CIC_ORDER * decim_log2 - 8;
  endfunction

  // Symbol -> weight; the invalid symbol contributes nothing.
  function automatic logic [1:0] sym_weight(input logic [1:0] sym);
    case (sym)
      SYM_POS: return LO_W_POS;
      SYM_NEG: return LO_W_NEG;
      default: return LO_W_ZERO;
    endcase
  endfunction

  // fs/4 LO: I = +1, 0, -1, 0 and Q = 0, +1, 0, -1 for phase 0..3.
  function automatic logic [1:0] lo_i_weight(input logic [1:0] phase);
    case (phase)
      2'd0:    return LO_W_POS;
      2'd2:    return LO_W_NEG;
      default: return LO_W_ZERO;
    endcase
  endfunction

  function automatic logic [1:0] lo_q_weight(input logic [1:0] phase);
    case (phase)
      2'd1:    return LO_W_POS;
      2'd3:    return LO_W_NEG;
      default: return LO_W_ZERO;
    endcase
  endfunction

  // Product of two ternary weights, result again in {-1, 0, +1}.
  function automatic logic [1:0] mix_weight(input logic [1:0] a,
                                            input logic [1:0] b);
    logic a_nz;
    logic b_nz;
    a_nz = (a == LO_W_POS) || (a == LO_W_NEG);
    b_nz = (b == LO_W_POS) || (b == LO_W_NEG);
    if (a_nz && b_nz) return (a == b) ? LO_W_POS : LO_W_NEG;
    return LO_W_ZERO;
  endfunction

endpackage

// File: rtl/dsm_rx_demod_cic_decim.sv
// cic_decim
//   One rail of the receiver decimator: 3rd-order CIC (differential delay 1)
//   with decimation by R = 2**DECIM_LOG2, followed by scaling to 8 bits.
//   The incoming weight and strobes are registered first, so the integrators
//   update one edge after a sample is accepted; the comb chain and scaling
//   are combinational off integrator 3 and the comb delays advance on the
//   edge the result is taken.
//   Configuration macro: DSM_RX_SAT_EN (saturate to [-128, 127]); when
//   undefined the low 8 bits of the shifted value are taken.
// Ports
//   clock         system clock
//   i_clear       synchronous clear of all state (reset or LO restart)
//   i_weight      mixed sample, ternary weight encoding
//   i_sample      sample strobe (accepted sample)
//   i_decim       decimate strobe (last sample of the window)
//   o_result      scaled 8-bit result, valid with o_result_stb
//   o_result_stb  one-cycle result strobe
module cic_decim
  import dsm_pkg::*;
#(
  parameter int DECIM_LOG2 = 4
) (
  input  logic       clock,
  input  logic       i_clear,
  input  logic [1:0] i_weight,
  input  logic       i_sample,
  input  logic       i_decim,
  output logic [7:0] o_result,
  output logic       o_result_stb
);

  localparam int ACC_W = cic_acc_w(DECIM_LOG2);
  localparam int SHIFT = cic_shift(DECIM_LOG2);

  logic [1:0]              r_x;
  logic                    r_smp;
  logic                    r_dec;
  logic                    r_dump;
  logic signed [ACC_W-1:0] r_int1, r_int2, r_int3;
  logic signed [ACC_W-1:0] r_dly1, r_dly2, r_dly3;

  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_int1, w_int2, w_int3;
  logic signed [ACC_W-1:0] w_c1, w_c2, w_c3;
  logic signed [ACC_W-1:0] w_shifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_x = '0;
    if (r_x == LO_W_POS)      w_x = ACC_W'(1);
    else if (r_x == LO_W_NEG) w_x = '1;
  end

  // Integrators chain on the freshly updated value of the stage before, so a
  // sample reaches integrator 3 on the same edge it enters integrator 1.
  // Two's-complement wrap is intentional; the combs undo it.
  assign w_int1 = r_int1 + w_x;
  assign w_int2 = r_int2 + w_int1;
  assign w_int3 = r_int3 + w_int2;

  assign w_c1 = r_int3 - r_dly1;
  assign w_c2 = w_c1   - r_dly2;
  assign w_c3 = w_c2   - r_dly3;

  assign w_shifted = w_c3 >>> SHIFT;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_x    <= LO_W_ZERO;
      r_smp  <= 1'b0;
      r_dec  <= 1'b0;
      r_dump <= 1'b0;
      r_int1 <= '0;
      r_int2 <= '0;
      r_int3 <= '0;
      r_dly1 <= '0;
      r_dly2 <= '0;
      r_dly3 <= '0;
    end else begin
      r_x    <= i_weight;
      r_smp  <= i_sample;
      r_dec  <= i_decim;
      r_dump <= r_smp && r_dec;
      if (r_smp) begin
        r_int1 <= w_int1;
        r_int2 <= w_int2;
        r_int3 <= w_int3;
      end
      // Combs advance once per window, on the edge the result is taken.
      if (r_dump) begin
        r_dly1 <= r_int3;
        r_dly2 <= w_c1;
        r_dly3 <= w_c2;
      end
    end
  end

  // A clear on the result edge discards the result along with the state.
  assign o_result_stb = r_dump && !i_clear;

`ifdef DSM_RX_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  always_comb begin
    o_result = w_shifted[7:0];
    if (w_shifted > SAT_HI)      o_result = 8'h7f;
    else if (w_shifted < SAT_LO) o_result = 8'h80;
  end
`else
  // Wrap: the single full-scale positive value +128 reads back as -128.
  assign o_result = w_shifted[7:0];

  logic w_unused_msbs;
  assign w_unused_msbs = ^w_shifted[ACC_W-1:8];
`endif

endmodule

// File: rtl/dsm_rx_demod.sv
// dsm_rx_demod
//   Loopback receiver for one transmit beamformer channel. Decodes the 2-bit
//   delta-sigma symbol stream, mixes it with the fs/4 LO shared with the
//   transmitter, decimates I and Q through a 3rd-order CIC and presents 8-bit
//   signed baseband samples on a valid/ready output with sticky overrun and
//   invalid-symbol flags.
//   Configuration macro: DSM_RX_SAT_EN (saturating output scaling, used in
//   cic_decim); undefined selects wrapping.
// Ports
//   clock, reset  system clock, synchronous active-high reset
//   en            sample enable; low freezes LO, counter and integrators
//   lo_sync       restart LO phase, counter, integrators and comb delays
//   sym_in        DSM symbol: 00 = 0, 01 = +1, 10 = -1, 11 = invalid
//   out_i, out_q  signed baseband sample, held while out_valid
//   out_valid     output sample held
//   out_ready     consumer accepts the held sample
//   overrun       sticky: a result was dropped while the output was held
//   bad_sym       sticky: symbol 11 was received
//   clr_flags     clears overrun and bad_sym (a same-cycle set wins)
module dsm_rx_demod
  import dsm_pkg::*;
#(
  parameter int DECIM_LOG2 = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              lo_sync,
  input  logic [1:0]        sym_in,
  output logic signed [7:0] out_i,
  output logic signed [7:0] out_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              bad_sym,
  input  logic              clr_flags
);

  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

  logic [1:0]            r_phase;
  logic [DECIM_LOG2-1:0] r_cnt;
  logic signed [7:0]     r_out_i, r_out_q;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_bad;

  logic                  w_accept;
  logic                  w_decim;
  logic                  w_cic_clr;
  logic [1:0]            w_sym_w;
  logic [1:0]            w_mix_i, w_mix_q;
  logic [7:0]            w_res_i, w_res_q;
  logic                  w_stb_i, w_stb_q;
  logic                  w_res_stb;
  logic signed [7:0]     w_out_i_n, w_out_q_n;
  logic                  w_valid_n;
  logic                  w_ovr_set;
  logic                  w_bad_set;

  // lo_sync outranks en: a restart cycle never accepts a sample.
  assign w_accept  = en && !lo_sync;
  assign w_decim   = w_accept && (r_cnt == CNT_LAST);
  assign w_cic_clr = reset || lo_sync;

  assign w_sym_w = sym_weight(sym_in);
  assign w_mix_i = mix_weight(w_sym_w, lo_i_weight(r_phase));
  assign w_mix_q = mix_weight(w_sym_w, lo_q_weight(r_phase));

  assign w_bad_set = w_accept && (sym_in == SYM_BAD);

  always_ff @(posedge clock) begin
    if (reset || lo_sync) begin
      r_phase <= '0;
      r_cnt   <= '0;
    end else if (en) begin
      r_phase <= r_phase + 2'd1;
      r_cnt   <= r_cnt + DECIM_LOG2'(1);
    end
  end

  cic_decim #(.DECIM_LOG2(DECIM_LOG2)) u_cic_i (
    .clock        (clock),
    .i_clear      (w_cic_clr),
    .i_weight     (w_mix_i),
    .i_sample     (w_accept),
    .i_decim      (w_decim),
    .o_result     (w_res_i),
    .o_result_stb (w_stb_i)
  );

  cic_decim #(.DECIM_LOG2(DECIM_LOG2)) u_cic_q (
    .clock        (clock),
    .i_clear      (w_cic_clr),
    .i_weight     (w_mix_q),
    .i_sample     (w_accept),
    .i_decim      (w_decim),
    .o_result     (w_res_q),
    .o_result_stb (w_stb_q)
  );

  // Both rails run in lockstep; their strobes are always equal.
  assign w_res_stb = w_stb_i && w_stb_q;

  // Output holding register. A new result may replace the held one only if
  // it is being transferred this cycle; otherwise the new one is dropped.
  always_comb begin
    w_out_i_n = r_out_i;
    w_out_q_n = r_out_q;
    w_valid_n = r_valid;
    w_ovr_set = 1'b0;
    if (w_res_stb) begin
      if (!r_valid || out_ready) begin
        w_out_i_n = w_res_i;
        w_out_q_n = w_res_q;
        w_valid_n = 1'b1;
      end else begin
        w_ovr_set = 1'b1;
      end
    end else if (r_valid && out_ready) begin
      w_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_i   <= '0;
      r_out_q   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      r_out_i   <= w_out_i_n;
      r_out_q   <= w_out_q_n;
      r_valid   <= w_valid_n;
      r_overrun <= w_ovr_set || (r_overrun && !clr_flags);
      r_bad     <= w_bad_set || (r_bad && !clr_flags);
    end
  end

  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;
  assign bad_sym   = r_bad;

endmodule
